// File: rtl/pa_spsram_2048x32_ctrl_if.sv
// Request/response bus between a requester and the 2048x32 single-port SRAM controller.
interface pa_spsram_2048x32_ctrl_if;
    logic        req_vld;
    logic        req_rdy;
    logic        req_wr;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdata;

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdata
    );

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdata
    );
endinterface

// File: rtl/pa_spsram_2048x32_ctrl.sv
// Controller for a 2048x32 single-port SRAM with a 1-cycle read latency and a one-entry response hold.
// Optional macro PA_SPSRAM_CTRL_INIT_EN adds a post-reset pass that zero-fills the whole array.
module pa_spsram_2048x32_ctrl (
    input  logic                          forever_cpuclk,
    input  logic                          cpurst,
    pa_spsram_2048x32_ctrl_if.slave       bus,
    output logic [10:0]                   A,
    output logic                          CEN,
    output logic                          GWEN,
    output logic [31:0]                   WEN,
    output logic [31:0]                   D,
    input  logic [31:0]                   Q
);

`ifdef PA_SPSRAM_CTRL_INIT_EN
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RDQ, ST_HOLD} state_t;
    logic [10:0] init_cnt;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RDQ, ST_HOLD} state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [31:0] hold_q;
    logic        rdy;
    logic        vld;
    logic [31:0] rdata;
    logic        accept;

    assign bus.req_rdy   = rdy;
    assign bus.rsp_vld   = vld;
    assign bus.rsp_rdata = rdata;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
`ifdef PA_SPSRAM_CTRL_INIT_EN
            state    <= ST_INIT;
            init_cnt <= '0;
`else
            state    <= ST_IDLE;
`endif
            hold_q   <= '0;
        end else begin
            state <= state_nxt;
            // Q is only valid in the RDQ cycle; park it when the consumer stalls.
            if (state == ST_RDQ && !bus.rsp_rdy)
                hold_q <= Q;
`ifdef PA_SPSRAM_CTRL_INIT_EN
            if (state == ST_INIT)
                init_cnt <= init_cnt + 11'd1;
`endif
        end
    end

    // All outputs are held at their idle values while reset is asserted.
    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        vld       = 1'b0;
        rdata     = '0;
        accept    = 1'b0;
        CEN       = 1'b1;
        GWEN      = 1'b1;
        WEN       = '1;
        A         = '0;
        D         = '0;
        if (!cpurst) begin
            case (state)
`ifdef PA_SPSRAM_CTRL_INIT_EN
                ST_INIT: begin
                    CEN  = 1'b0;
                    GWEN = 1'b0;
                    WEN  = '0;
                    A    = init_cnt;
                    if (init_cnt == '1)
                        state_nxt = ST_IDLE;
                end
`endif
                ST_IDLE: begin
                    rdy = 1'b1;
                end
                ST_RDQ: begin
                    vld       = 1'b1;
                    rdata     = Q;
                    rdy       = bus.rsp_rdy;
                    state_nxt = bus.rsp_rdy ? ST_IDLE : ST_HOLD;
                end
                ST_HOLD: begin
                    vld   = 1'b1;
                    rdata = hold_q;
                    if (bus.rsp_rdy)
                        state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = state;
                end
            endcase

            accept = bus.req_vld & rdy;
            if (accept) begin
                CEN  = 1'b0;
                A    = bus.req_addr;
                GWEN = ~bus.req_wr;
                D    = bus.req_wdata;
                if (bus.req_wr) begin
                    for (int unsigned i = 0; i < 4; i++)
                        WEN[8*i +: 8] = {8{~bus.req_be[i]}};
                end else begin
                    state_nxt = ST_RDQ;
                end
            end
        end
    end

endmodule

// File: tb/tb_pa_spsram_2048x32_ctrl.sv
// Directed self-checking bench for pa_spsram_2048x32_ctrl with a behavioural SRAM model.
// Covers the PA_SPSRAM_CTRL_INIT_EN zero-fill pass when that macro is defined.
module tb_pa_spsram_2048x32_ctrl;

    logic        clk;
    logic        cpurst;
    logic [10:0] A;
    logic        CEN;
    logic        GWEN;
    logic [31:0] WEN;
    logic [31:0] D;
    logic [31:0] Q;
    logic [31:0] mem [0:2047];
    int          checks;
    int          errors;
    logic [31:0] seq_exp [0:3];

    pa_spsram_2048x32_ctrl_if bus ();

    pa_spsram_2048x32_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst         (cpurst),
        .bus            (bus.slave),
        .A              (A),
        .CEN            (CEN),
        .GWEN           (GWEN),
        .WEN            (WEN),
        .D              (D),
        .Q              (Q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Q reads back garbage on non-read cycles so a stale-Q response is visible.
    always @(posedge clk) begin
        if (!CEN && !GWEN) begin
            mem[A] <= (mem[A] & WEN) | (D & ~WEN);
            Q      <= 32'hDEAD_BEEF;
        end else if (!CEN) begin
            Q <= mem[A];
        end else begin
            Q <= 32'hDEAD_BEEF;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic wr, input logic [10:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        bus.req_vld   = vld;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cpurst = 1'b1;
        bus.rsp_rdy = 1'b1;
        drive(1'b1, 1'b1, 11'h155, 32'h1234_5678, 4'hF);
        step();
        step();
        #1;
        chk("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
        chk("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_cen", 32'(CEN), 32'd1);
        chk("rst_gwen", 32'(GWEN), 32'd1);
        chk("rst_wen", WEN, 32'hFFFF_FFFF);
        chk("rst_a", 32'(A), 32'h0);
        chk("rst_d", D, 32'h0);

        drive(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        step();
        cpurst = 1'b0;
        #1;
`ifdef PA_SPSRAM_CTRL_INIT_EN
        for (int i = 0; i < 2048; i++) begin
            chk("init_a", 32'(A), 32'(i));
            chk("init_cen", 32'(CEN), 32'd0);
            chk("init_gwen", 32'(GWEN), 32'd0);
            chk("init_wen", WEN, 32'h0);
            chk("init_d", D, 32'h0);
            chk("init_req_rdy", 32'(bus.req_rdy), 32'd0);
            step();
        end
        chk("init_done_req_rdy", 32'(bus.req_rdy), 32'd1);
        drive(1'b1, 1'b0, 11'h400, 32'h0, 4'h0);
        step();
        drive(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        #1;
        chk("init_rd400_vld", 32'(bus.rsp_vld), 32'd1);
        chk("init_rd400_data", bus.rsp_rdata, 32'h0);
        step();
`else
        chk("post_rst_req_rdy", 32'(bus.req_rdy), 32'd1);
`endif

        // Full-word write then read of 0x123
        drive(1'b1, 1'b1, 11'h123, 32'hA5A5_5A5A, 4'hF);
        #1;
        chk("wr123_cen", 32'(CEN), 32'd0);
        chk("wr123_gwen", 32'(GWEN), 32'd0);
        chk("wr123_wen", WEN, 32'h0);
        chk("wr123_a", 32'(A), 32'h123);
        chk("wr123_d", D, 32'hA5A5_5A5A);
        step();
        drive(1'b1, 1'b0, 11'h123, 32'h0, 4'h0);
        #1;
        chk("wr_no_rsp", 32'(bus.rsp_vld), 32'd0);
        chk("rd123_gwen", 32'(GWEN), 32'd1);
        chk("rd123_wen", WEN, 32'hFFFF_FFFF);
        chk("rd123_cen", 32'(CEN), 32'd0);
        step();
        drive(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        #1;
        chk("rd123_vld", 32'(bus.rsp_vld), 32'd1);
        chk("rd123_data", bus.rsp_rdata, 32'hA5A5_5A5A);
        step();
        chk("rd123_idle_vld", 32'(bus.rsp_vld), 32'd0);
        chk("rd123_idle_data", bus.rsp_rdata, 32'h0);
        chk("idle_cen", 32'(CEN), 32'd1);

        // Partial-byte write to 0x7FF over all-ones
        drive(1'b1, 1'b1, 11'h7FF, 32'hFFFF_FFFF, 4'hF);
        step();
        drive(1'b1, 1'b1, 11'h7FF, 32'h1122_3344, 4'b0101);
        #1;
        chk("wr7ff_wen", WEN, 32'hFF00_FF00);
        step();
        drive(1'b1, 1'b0, 11'h7FF, 32'h0, 4'h0);
        step();
        drive(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        #1;
        chk("rd7ff_data", bus.rsp_rdata, 32'hFF22_FF44);
        step();

        // Back-to-back writes then reads of 0..3
        for (int i = 0; i < 4; i++) begin
            seq_exp[i] = 32'h1000_0000 + 32'(i);
            drive(1'b1, 1'b1, 11'(i), seq_exp[i], 4'hF);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 11'(k), 32'h0, 4'h0);
            #1;
            chk("seq_req_rdy", 32'(bus.req_rdy), 32'd1);
            if (k > 0) begin
                chk("seq_vld", 32'(bus.rsp_vld), 32'd1);
                chk("seq_data", bus.rsp_rdata, seq_exp[k-1]);
            end
            step();
        end
        drive(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        #1;
        chk("seq_last_vld", 32'(bus.rsp_vld), 32'd1);
        chk("seq_last_data", bus.rsp_rdata, seq_exp[3]);
        step();
        chk("seq_end_vld", 32'(bus.rsp_vld), 32'd0);

        // Stalled response goes to HOLD and stays stable
        bus.rsp_rdy = 1'b0;
        drive(1'b1, 1'b0, 11'h1, 32'h0, 4'h0);
        step();
        drive(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        #1;
        chk("rdq_stall_vld", 32'(bus.rsp_vld), 32'd1);
        chk("rdq_stall_data", bus.rsp_rdata, 32'h1000_0001);
        chk("rdq_stall_req_rdy", 32'(bus.req_rdy), 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 11'h2, 32'h0, 4'h0);
            #1;
            chk("hold_vld", 32'(bus.rsp_vld), 32'd1);
            chk("hold_data", bus.rsp_rdata, 32'h1000_0001);
            chk("hold_req_rdy", 32'(bus.req_rdy), 32'd0);
            chk("hold_cen", 32'(CEN), 32'd1);
            step();
        end
        drive(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        bus.rsp_rdy = 1'b1;
        #1;
        chk("hold_release_vld", 32'(bus.rsp_vld), 32'd1);
        chk("hold_release_data", bus.rsp_rdata, 32'h1000_0001);
        step();
        chk("hold_after_vld", 32'(bus.rsp_vld), 32'd0);
        chk("hold_after_req_rdy", 32'(bus.req_rdy), 32'd1);

        // Reset while in HOLD drops the pending response
        bus.rsp_rdy = 1'b0;
        drive(1'b1, 1'b0, 11'h2, 32'h0, 4'h0);
        step();
        drive(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        step();
        chk("pre_rst_hold_vld", 32'(bus.rsp_vld), 32'd1);
        chk("pre_rst_hold_data", bus.rsp_rdata, 32'h1000_0002);
        cpurst = 1'b1;
        step();
        chk("rst_hold_vld", 32'(bus.rsp_vld), 32'd0);
        chk("rst_hold_cen", 32'(CEN), 32'd1);
        chk("rst_hold_data", bus.rsp_rdata, 32'h0);
        cpurst = 1'b0;
        bus.rsp_rdy = 1'b1;
`ifdef PA_SPSRAM_CTRL_INIT_EN
        for (int i = 0; i < 2048; i++) begin
            #1;
            chk("reinit_vld", 32'(bus.rsp_vld), 32'd0);
            step();
        end
        // The zero-fill pass wiped the earlier contents.
        for (int i = 0; i < 4; i++)
            seq_exp[i] = 32'h0;
`endif
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_no_rsp", 32'(bus.rsp_vld), 32'd0);
            chk("post_rst_rdy", 32'(bus.req_rdy), 32'd1);
            step();
        end

        // Write with no byte enables still strobes CEN but changes nothing
        drive(1'b1, 1'b1, 11'h0, 32'hFFFF_FFFF, 4'h0);
        #1;
        chk("be0_cen", 32'(CEN), 32'd0);
        chk("be0_gwen", 32'(GWEN), 32'd0);
        chk("be0_wen", WEN, 32'hFFFF_FFFF);
        step();
        drive(1'b1, 1'b0, 11'h0, 32'h0, 4'h0);
        step();
        drive(1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
        #1;
        chk("be0_readback", bus.rsp_rdata, seq_exp[0]);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pa_spsram_2048x32_ctrl.md
PA_SPSRAM_2048X32_CTRL -- requirements
Module: pa_spsram_2048x32_ctrl

Interface
REQ-001 forever_cpuclk  in  1  sole clock; all state updates on rising edge.
REQ-002 cpurst  in  1  synchronous reset, active-high.
REQ-003 req_vld  in  1  request valid.
REQ-004 req_rdy  out  1  request accepted when req_vld & req_rdy at a rising edge.
REQ-005 req_wr  in  1  1 = write, 0 = read.
REQ-006 req_addr  in  11  word address.
REQ-007 req_wdata  in  32  write data.
REQ-008 req_be  in  4  byte enables, active-high; bit i covers data bits 8i+7:8i.
REQ-009 rsp_vld  out  1  read data valid.
REQ-010 rsp_rdy  in  1  response consumed when rsp_vld & rsp_rdy at a rising edge.
REQ-011 rsp_rdata  out  32  read data.
REQ-012 A  out  11  SRAM address.
REQ-013 CEN  out  1  SRAM chip enable, active-low.
REQ-014 GWEN  out  1  SRAM global write enable, active-low.
REQ-015 WEN  out  32  SRAM per-bit write enable, active-low.
REQ-016 D  out  32  SRAM write data.
REQ-017 Q  in  32  SRAM read data, valid the cycle after a read access.

Function
REQ-018 States: INIT (macro only), IDLE, RDQ (read data on Q this cycle), HOLD (response captured, awaiting rsp_rdy).
REQ-019 req_rdy = (state==IDLE) | (state==RDQ & rsp_rdy); 0 in INIT and HOLD.
REQ-020 On acceptance, SRAM pins driven combinationally same cycle: CEN=0, A=req_addr, GWEN=~req_wr, D=req_wdata.
REQ-021 Write WEN[8i+7:8i] = {8{~req_be[i]}}; read WEN = all ones; req_be=0 write still pulses CEN with no bits written.
REQ-022 No access cycle: CEN=1, GWEN=1, WEN=32'hFFFF_FFFF, A=0, D=0.
REQ-023 Writes produce no response; state after accepted write is IDLE.
REQ-024 Accepted read at cycle N -> state RDQ at N+1, rsp_vld=1, rsp_rdata=Q (1-cycle latency).
REQ-025 RDQ & rsp_rdy: next state RDQ if new read accepted, else IDLE.
REQ-026 RDQ & ~rsp_rdy: Q captured into 32-bit hold register, next state HOLD.
REQ-027 HOLD: rsp_vld=1, rsp_rdata=hold register, stable until rsp_rdy; then IDLE.
REQ-028 Back-to-back reads sustain one per cycle while rsp_rdy=1.
REQ-029 rsp_vld=0 in IDLE and INIT; rsp_rdata=0 when rsp_vld=0.

Reset
REQ-030 cpurst=1: state -> INIT if macro defined else IDLE; hold register -> 0; init counter -> 0.
REQ-031 Reset values: req_rdy=0, rsp_vld=0, rsp_rdata=0, CEN=1, GWEN=1, WEN=all ones, A=0, D=0.
REQ-032 Reset mid-read or in HOLD discards pending response; no rsp_vld after reset deasserts until a new read.

Configuration
REQ-033 Macro PA_SPSRAM_CTRL_INIT_EN defined: after reset, INIT writes zero to addresses 0..2047, one per cycle (CEN=0, GWEN=0, WEN=0, D=0, A=counter), then IDLE; req_rdy=0 throughout.
REQ-034 INIT_EN defined: first req_rdy=1 is exactly 2048 cycles after the first cycle with cpurst=0; counter wraps 2047 -> done.
REQ-035 Macro undefined: no INIT state or counter; IDLE and req_rdy=1 the first cycle after reset deasserts.

Verification
REQ-036 Write addr 0x123, wdata 0xA5A5_5A5A, be 4'hF; read 0x123 -> rsp_vld next cycle, rsp_rdata 0xA5A5_5A5A.
REQ-037 Write 0x7FF be 4'b0101 data 0x1122_3344 over 0xFFFF_FFFF -> WEN=0xFF00_FF00, readback 0xFF22_FF44.
REQ-038 Reads to 0,1,2,3 on consecutive cycles, rsp_rdy=1 -> four rsp_vld cycles in order, req_rdy never low.
REQ-039 Read, rsp_rdy=0 for 5 cycles -> HOLD, req_rdy=0, rsp_rdata stable; rsp_rdy=1 -> one response, IDLE.
REQ-040 Reset asserted in HOLD -> rsp_vld=0 next cycle, CEN=1; no stale response after release.
REQ-041 INIT_EN: release reset -> 2048 write cycles A=0..2047, then req_rdy=1; read 0x400 -> 0x0000_0000.
